// File: rtl/array_pkg.sv
// Shared types and helpers for the byte-enable RAM and its init sequencer.
package array_pkg;

    typedef enum logic {INIT, READY} arr_state_t;
    typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_t;

    // Widest word the merge helper handles; callers cast to and from their own width.
    localparam int MAX_W  = 256;
    localparam int MAX_BE = MAX_W / 8;

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] merged;
        merged = old_w;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/array_init_seq.sv
// Init/ready state machine: sweeps every entry with zeros after reset or clear.
module array_init_seq
    import array_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          ready,
    output logic          init_we,
    output logic [AW-1:0] init_addr
);

    arr_state_t    state_r;
    logic [AW-1:0] cnt_r;
    logic          ready_r;

    // State, sweep counter and registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= INIT;
            cnt_r   <= {AW{1'b0}};
            ready_r <= 1'b0;
        end else if (clear) begin
            state_r <= INIT;
            cnt_r   <= {AW{1'b0}};
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    if (cnt_r == AW'(DEPTH - 1)) begin
                        state_r <= READY;
                        cnt_r   <= {AW{1'b0}};
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + AW'(1);
                    end
                end
                READY: begin
                    state_r <= READY;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= INIT;
                    cnt_r   <= {AW{1'b0}};
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign init_we   = (state_r == INIT);
    assign init_addr = cnt_r;

endmodule

// File: rtl/array_ram_be.sv
// Dual-port (one write, one read) RAM with byte enables, read-during-write
// selection, out-of-range detection and zero-sweep initialisation.
module array_ram_be
    import array_pkg::*;
#(
    parameter int        WIDTH    = 16,
    parameter int        DEPTH    = 6,
    parameter int        AW       = $clog2(DEPTH),
    parameter rdw_mode_t RDW_MODE = RDW_OLD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    output logic               ready,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_err
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic             ready_s;
    logic             init_we_s;
    logic [AW-1:0]    init_addr_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic             rd_in_range_s;
    logic [WIDTH-1:0] stored_wr_s;
    logic [WIDTH-1:0] wr_merged_s;
    logic [WIDTH-1:0] rd_word_s;

    // No reset on the array: the sweep provides the zero guarantee.
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic             rd_valid_r;
    logic             rd_err_r;
    logic [WIDTH-1:0] rd_data_r;

    array_init_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .ready     (ready_s),
        .init_we   (init_we_s),
        .init_addr (init_addr_s)
    );

    // Request acceptance, byte merge and read-during-write result selection
    always_comb begin
        wr_ok_s       = ready_s && wr_en && ({1'b0, wr_addr} < DEPTH_L);
        rd_ok_s       = ready_s && rd_en;
        rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
        stored_wr_s   = {WIDTH{1'b0}};
        rd_word_s     = {WIDTH{1'b0}};
        if (wr_ok_s) begin
            stored_wr_s = mem_r[wr_addr];
        end else begin
            stored_wr_s = {WIDTH{1'b0}};
        end
        wr_merged_s = WIDTH'(byte_merge(MAX_W'(stored_wr_s), MAX_W'(wr_data), MAX_BE'(wr_be)));
        if (rd_in_range_s) begin
            rd_word_s = mem_r[rd_addr];
        end else begin
            rd_word_s = {WIDTH{1'b0}};
        end
        if ((RDW_MODE == RDW_NEW) && wr_ok_s && rd_in_range_s && (wr_addr == rd_addr)) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = rd_word_s;
        end
    end

    // Storage update: sweep zeros take priority over user writes
    always_ff @(posedge clk) begin
        if (init_we_s) begin
            mem_r[init_addr_s] <= {WIDTH{1'b0}};
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_merged_s;
        end
    end

    // Registered read response; data holds between accepted reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
        end else if (rd_ok_s) begin
            rd_valid_r <= 1'b1;
            rd_err_r   <= !rd_in_range_s;
            rd_data_r  <= rd_word_s;
        end else begin
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
        end
    end

    assign ready    = ready_s;
    assign rd_valid = rd_valid_r;
    assign rd_err   = rd_err_r;
    assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_array_ram_be.sv
// Directed bench for array_ram_be: one instance per read-during-write mode.
module tb_array_ram_be;
    import array_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [2:0]  rd_addr = 3'd0;
    logic [1:0]  wr_be = 2'b00;
    logic [15:0] wr_data = 16'h0000;

    logic        ready, rd_valid, rd_err;
    logic [15:0] rd_data;
    logic        n_ready, n_rd_valid, n_rd_err;
    logic [15:0] n_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    logic [15:0] exp_mem [6];

    always #5 clk = ~clk;

    array_ram_be #(.WIDTH(16), .DEPTH(6), .RDW_MODE(RDW_OLD)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err)
    );

    array_ram_be #(.WIDTH(16), .DEPTH(6), .RDW_MODE(RDW_NEW)) dut_new (
        .clk(clk), .rst_n(rst_n), .clear(clear), .ready(n_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(n_rd_valid),
        .rd_data(n_rd_data), .rd_err(n_rd_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] d, input logic err);
        rd_addr = a;
        rd_en   = 1'b1;
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(d));
        check({tag, "_err"}, 32'(rd_err), 32'(err));
    endtask

    // Counts edges until ready rises (bounded), tallying rd_valid pulses seen meanwhile.
    task automatic wait_ready(input string tag, input int start, input int exp);
        int n;
        n = start;
        n_pulses = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (rd_valid === 1'b1) n_pulses++;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        // Power-up reset and first sweep
        #12;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        rst_n = 1'b1;
        wait_ready("init_latency", 0, 6);

        // 1: garbage, reset pulse, sweep zeroes everything
        for (int i = 0; i < 6; i++) wr(3'(i), 16'hDEA0 | 16'(i), 2'b11);
        #4;
        rst_n = 1'b0;
        #1;
        check("reset_ready_low", 32'(ready), 32'd0);
        #1;
        rst_n = 1'b1;
        wait_ready("reset_latency", 0, 6);
        for (int i = 0; i < 6; i++) rd_chk("sweep", 3'(i), 16'h0000, 1'b0);

        // 2: byte enables
        wr(3'd2, 16'hABCD, 2'b11);
        wr(3'd2, 16'h1234, 2'b01);
        rd_chk("be_merge", 3'd2, 16'hAB34, 1'b0);
        @(posedge clk);
        #1;
        check("be_pulse_once", 32'(rd_valid), 32'd0);
        check("be_data_hold", 32'(rd_data), 32'h0000AB34);

        // 3: read-during-write, both modes
        wr(3'd3, 16'h5555, 2'b11);
        wr_addr = 3'd3; wr_data = 16'hAAAA; wr_be = 2'b10; wr_en = 1'b1;
        rd_addr = 3'd3; rd_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw_old_data", 32'(rd_data), 32'h00005555);
        check("rdw_new_data", 32'(n_rd_data), 32'h0000AA55);
        check("rdw_new_valid", 32'(n_rd_valid), 32'd1);
        check("rdw_new_err", 32'(n_rd_err), 32'd0);
        check("rdw_new_ready", 32'(n_ready), 32'd1);
        rd_chk("rdw_after", 3'd3, 16'hAA55, 1'b0);
        check("rdw_after_new", 32'(n_rd_data), 32'h0000AA55);

        // 4: out-of-range write dropped, out-of-range read flagged
        wr(3'd7, 16'hFFFF, 2'b11);
        exp_mem[0] = 16'h0000; exp_mem[1] = 16'h0000; exp_mem[2] = 16'hAB34;
        exp_mem[3] = 16'hAA55; exp_mem[4] = 16'h0000; exp_mem[5] = 16'h0000;
        for (int i = 0; i < 6; i++) rd_chk("oor_intact", 3'(i), exp_mem[i], 1'b0);
        rd_chk("oor_rd6", 3'd6, 16'h0000, 1'b1);
        rd_chk("oor_rd7", 3'd7, 16'h0000, 1'b1);
        rd_chk("oor_err_clears", 3'd2, 16'hAB34, 1'b0);

        // 5: clear with a concurrent read; requests held during INIT are ignored
        wr(3'd1, 16'h00FF, 2'b11);
        clear = 1'b1; rd_addr = 3'd1; rd_en = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_rd_valid", 32'(rd_valid), 32'd1);
        check("clr_rd_data", 32'(rd_data), 32'h000000FF);
        check("clr_ready_low", 32'(ready), 32'd0);
        wr_addr = 3'd0; wr_data = 16'h1234; wr_be = 2'b11; wr_en = 1'b1;
        wait_ready("clear_latency", 1, 7);
        wr_en = 1'b0; rd_en = 1'b0;
        check("init_no_rd_valid", 32'(n_pulses), 32'd0);
        rd_chk("clr_addr0", 3'd0, 16'h0000, 1'b0);
        rd_chk("clr_addr1", 3'd1, 16'h0000, 1'b0);
        rd_chk("clr_addr2", 3'd2, 16'h0000, 1'b0);

        // 6: async reset at sweep counter 3
        wr(3'd5, 16'hBEEF, 2'b11);
        clear = 1'b1; rd_addr = 3'd5; rd_en = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; rd_en = 1'b0;
        check("mid_rd_data", 32'(rd_data), 32'h0000BEEF);
        repeat (3) @(posedge clk);
        #1;
        check("mid_hold", 32'(rd_data), 32'h0000BEEF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(rd_data), 32'd0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        #2;
        rst_n = 1'b1;
        wait_ready("restart_latency", 0, 6);
        rd_chk("mid_addr5", 3'd5, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
